// File: rtl/key_capture_pio.sv
// -----------------------------------------------------------------------------
// key_capture_pio
//
// Avalon-MM slave that carries push-button and switch levels from the FPGA
// fabric to the HPS over the lightweight HPS-to-FPGA bridge. Each input bit is
// handled in three steps:
//   - a 2-flop synchroniser
//   - a debouncer that produces the stable level
//   - a rising-edge detector feeding a sticky write-1-to-clear capture register
// A level interrupt is raised when any captured edge is enabled in IRQMASK.
//
// Build option:
//   KEY_CAPTURE_DEBOUNCE_EN  defined   -> per-bit debounce counters are built.
//                            undefined -> stable is the synchroniser output
//                                         delayed one register, and
//                                         DEBOUNCE_CYCLES has no effect.
//
// Register map (word addresses; bits above WIDTH-1 read as 0):
//   0  DATA     RO    debounced stable level (writes ignored)
//   1  RAW      RO    synchroniser output, before the debouncer
//   2  IRQMASK  RW    per-bit interrupt enable
//   3  EDGECAP  R/W1C sticky rising-edge flags; if an edge and a clear hit
//                     the same bit in the same cycle, the edge wins
//
// Ports:
//   clk                in   system clock (lightweight bridge domain)
//   reset              in   synchronous, active-high reset
//   avs_address[1:0]   in   register word address
//   avs_read           in   read strobe, one cycle per access
//   avs_write          in   write strobe, one cycle per access
//   avs_writedata[31:0]in   write data
//   avs_readdata[31:0] out  registered read data, held until the next read
//   avs_readdatavalid  out  high for one cycle, the cycle after avs_read
//   irq                out  level interrupt, |(EDGECAP & IRQMASK)
//   in_port[WIDTH-1:0] in   asynchronous active-high board inputs
// -----------------------------------------------------------------------------

module key_capture_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RAW     = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } reg_addr_e;

    // Reject unsupported parameter values at elaboration.
    if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("key_capture_pio: WIDTH must be 1..32 and DEBOUNCE_CYCLES >= 2");
    end

    // -------------------------------------------------------------------------
    // Input synchroniser. sync_raw is the value software sees in RAW.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_raw;

    // NOTE: every clocked process uses non-blocking assignments, so all flops
    // sample their inputs at the same edge and the two sync stages really are
    // two stages, not one.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync_raw  <= '0;
        end else begin
            sync_meta <= in_port;
            sync_raw  <= sync_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Debouncer. stable_next is the value the stable register takes at the
    // next edge; the edge detector looks at it directly so EDGECAP sets in the
    // same cycle that DATA changes.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;

`ifdef KEY_CAPTURE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt      [WIDTH];
    logic [CNT_W-1:0] db_cnt_next [WIDTH];

    // NOTE: every output of this block is given a default before the
    // per-bit decisions, so no path leaves a value unassigned and no latch
    // is inferred.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < WIDTH; i++) begin
            db_cnt_next[i] = db_cnt[i];
            if (sync_raw[i] == stable[i]) begin
                // Agreement, or a bounce back before terminal count: the
                // window restarts from zero.
                db_cnt_next[i] = '0;
            end else if (db_cnt[i] == CNT_TERMINAL) begin
                // Different for the full window: accept the new level.
                stable_next[i] = sync_raw[i];
                db_cnt_next[i] = '0;
            end else begin
                db_cnt_next[i] = db_cnt[i] + 1'b1;
            end
        end
    end

    // NOTE: the counter array is ordinary flops, not a RAM, so it is cleared
    // on reset like any other state; a reset mid-debounce restarts every
    // window.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= db_cnt_next[i];
            end
        end
    end
`else
    // No filtering: stable is the synchroniser output one register later.
    always_comb begin
        stable_next = sync_raw;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
        end else begin
            stable <= stable_next;
        end
    end

    // Rising edge of the stable level. The registered stable value plays the
    // role of the one-cycle-delayed copy, and stable_next the current level.
    logic [WIDTH-1:0] rise;
    assign rise = stable_next & ~stable;

    // -------------------------------------------------------------------------
    // Register writes.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] w1c_bits;
    logic             wr_mask;

    assign wr_mask  = avs_write && (reg_addr_e'(avs_address) == ADDR_IRQMASK);
    assign w1c_bits = (avs_write && (reg_addr_e'(avs_address) == ADDR_EDGECAP))
                      ? avs_writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr_mask) begin
                irq_mask <= avs_writedata[WIDTH-1:0];
            end
            // Clear first, then OR in new edges: an edge in the same cycle as
            // a clear of the same bit leaves the bit set.
            edge_cap <= (edge_cap & ~w1c_bits) | rise;
        end
    end

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata;

    // -------------------------------------------------------------------------
    // Read path. The mux looks at register values before this cycle's write,
    // so a read that collides with a write returns the pre-write value.
    // -------------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        unique case (reg_addr_e'(avs_address))
            ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
            ADDR_RAW:     rd_mux[WIDTH-1:0] = sync_raw;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
            default:      rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_key_capture_pio.sv
// -----------------------------------------------------------------------------
// tb_key_capture_pio
//
// Directed bench for key_capture_pio. The stimulus process pushes the expected
// read data into a queue when it issues a read; a monitor pops and compares
// whenever avs_readdatavalid is high. irq is checked directly after edges.
// Expected input-to-DATA latency follows KEY_CAPTURE_DEBOUNCE_EN.
// -----------------------------------------------------------------------------

module tb_key_capture_pio;

    localparam int WIDTH = 4;
    localparam int DB    = 16;
`ifdef KEY_CAPTURE_DEBOUNCE_EN
    // Clock edges from an in_port change until the stable register holds it.
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 3;
`endif

    logic             clk;
    logic             reset;
    logic [1:0]       avs_address;
    logic             avs_read;
    logic             avs_write;
    logic [31:0]      avs_writedata;
    logic [31:0]      avs_readdata;
    logic             avs_readdatavalid;
    logic             irq;
    logic [WIDTH-1:0] in_port;

    key_capture_pio #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .irq               (irq),
        .in_port           (in_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q  [$];
    string       name_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid read response must match the oldest outstanding
    // expectation; a response with nothing outstanding is an error.
    always @(negedge clk) begin
        if (avs_readdatavalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_readdatavalid: data 0x%08h with no read outstanding at %0t",
                         avs_readdata, $time);
            end else begin
                check(name_q.pop_front(), avs_readdata, exp_q.pop_front());
            end
        end
    end

    // One bus cycle: drive strobes, register the expectation for a read,
    // then step past the clock edge.
    task automatic bus_cycle(input logic rd, input logic [1:0] addr, input logic wr,
                             input logic [31:0] wdata, input logic [31:0] exp,
                             input string name);
        avs_read      = rd;
        avs_write     = wr;
        avs_address   = addr;
        avs_writedata = wdata;
        if (rd && !reset) begin
            exp_q.push_back(exp);
            name_q.push_back(name);
        end
        @(posedge clk);
        #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, "");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] prev1;
        logic [WIDTH-1:0] prev2;

        reset         = 1'b1;
        in_port       = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_address   = 2'd0;
        avs_writedata = 32'h0;
        @(posedge clk);
        #1;
        idle(1);
        // Read issued during reset must not produce readdatavalid.
        bus_cycle(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, "read_in_reset");
        reset = 1'b0;
        check("reset_readdatavalid", {31'h0, avs_readdatavalid}, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);

        // Reset values of all four registers, back-to-back reads.
        for (int a = 0; a < 4; a++) bus_cycle(1'b1, 2'(a), 1'b0, 32'h0, 32'h0, "reset_regs");
        idle(1);

        // Bit 0 rises: DATA reads 1 from exactly LAT cycles after the change.
        in_port = 4'h1;
        for (int c = 0; c < LAT + 2; c++)
            bus_cycle(1'b1, 2'd0, 1'b0, 32'h0, (c >= LAT) ? 32'h1 : 32'h0, "data_rise_timing");
        bus_cycle(1'b1, 2'd3, 1'b0, 32'h0, 32'h1, "edgecap_after_rise");
        check("irq_masked_off", {31'h0, irq}, 32'h0);

        // Enable the mask: irq rises after the write edge.
        bus_cycle(1'b0, 2'd2, 1'b1, 32'h1, 32'h0, "");
        check("irq_mask_on", {31'h0, irq}, 32'h1);
        // W1C collides with a read of EDGECAP: read returns pre-write value.
        bus_cycle(1'b1, 2'd3, 1'b1, 32'h1, 32'h1, "edgecap_rw_collision");
        check("irq_after_w1c", {31'h0, irq}, 32'h0);
        bus_cycle(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, "edgecap_cleared");
        bus_cycle(1'b1, 2'd2, 1'b0, 32'h0, 32'h1, "irqmask_readback");

        // DATA ignores writes; IRQMASK implements only WIDTH bits.
        bus_cycle(1'b0, 2'd0, 1'b1, 32'hFFFF_FFFF, 32'h0, "");
        bus_cycle(1'b1, 2'd0, 1'b0, 32'h0, 32'h1, "data_write_ignored");
        bus_cycle(1'b0, 2'd2, 1'b1, 32'hFFFF_FFFF, 32'h0, "");
        bus_cycle(1'b1, 2'd2, 1'b0, 32'h0, 32'hF, "irqmask_width");
        bus_cycle(1'b0, 2'd2, 1'b1, 32'h0, 32'h0, "");

`ifdef KEY_CAPTURE_DEBOUNCE_EN
        // Bit 1 bounces: 10 cycles high, 3 low, never long enough to pass.
        // RAW is the input delayed by the two synchroniser stages.
        prev1 = 4'h1;
        prev2 = 4'h1;
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 13; k++) begin
                in_port = (k < 10) ? 4'h3 : 4'h1;
                bus_cycle(1'b1, 2'd1, 1'b0, 32'h0, {28'h0, prev2}, "raw_follows_bounce");
                prev2 = prev1;
                prev1 = in_port;
            end
        end
        in_port = 4'h1;
        idle(4);
        bus_cycle(1'b1, 2'd0, 1'b0, 32'h0, 32'h1, "data_ignores_bounce");
        bus_cycle(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, "edgecap_ignores_bounce");
`endif

        // Debounced edge on bit 2 lands on the same edge as a W1C of bit 2.
        bus_cycle(1'b0, 2'd2, 1'b1, 32'h4, 32'h0, "");
        in_port = 4'h5;
        for (int c = 0; c < LAT - 1; c++)
            bus_cycle(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, "edgecap_before_edge");
        bus_cycle(1'b0, 2'd3, 1'b1, 32'h4, 32'h0, "");
        check("irq_edge_beats_w1c", {31'h0, irq}, 32'h1);
        bus_cycle(1'b1, 2'd3, 1'b0, 32'h0, 32'h4, "edgecap_edge_beats_w1c");
        bus_cycle(1'b1, 2'd0, 1'b0, 32'h0, 32'h5, "data_bit2");
        bus_cycle(1'b0, 2'd3, 1'b1, 32'h4, 32'h0, "");
        check("irq_bit2_cleared", {31'h0, irq}, 32'h0);
        bus_cycle(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, "edgecap_bit2_cleared");

        // Reset with a read pending, then all bits 0 -> F.
        reset   = 1'b1;
        in_port = 4'h0;
        bus_cycle(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, "read_with_reset");
        check("reset_suppresses_valid", {31'h0, avs_readdatavalid}, 32'h0);
        idle(2);
        reset = 1'b0;
        check("irq_after_reset", {31'h0, irq}, 32'h0);
        bus_cycle(1'b1, 2'd2, 1'b0, 32'h0, 32'h0, "irqmask_after_reset");
        in_port = 4'hF;
        for (int c = 0; c < LAT + 2; c++)
            bus_cycle(1'b1, 2'd0, 1'b0, 32'h0, (c >= LAT) ? 32'hF : 32'h0, "data_all_rise");
        bus_cycle(1'b1, 2'd3, 1'b0, 32'h0, 32'hF, "edgecap_all_rise");
        bus_cycle(1'b1, 2'd1, 1'b0, 32'h0, 32'hF, "raw_all_high");
        idle(3);
        check("reads_outstanding", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
